// File: rtl/cw_pkg.sv
// Shared types and helpers for the chaffing-and-winnowing sequencer.
// Holds the controller state encoding and the packet width rule.
package cw_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    SETTLE,
    EMIT
  } cw_ctrl_state_t;

  // One packet is {bit, tag, ctr}
  function automatic int pkt_w(input int tagsize, input int ctrsize);
    return 1 + tagsize + ctrsize;
  endfunction

endpackage

// File: rtl/cw.sv
// Chaffing-and-winnowing datapath: builds wheat/chaff packet pairs
// from a message, its tag cache and the message counter.
module cw
  import cw_pkg::*;
#(
  parameter int CWBITS    = 32,
  parameter int CTRSIZE   = 16,
  parameter int TAGSIZE   = 16,
  parameter int CACHESIZE = 64
) (
  input  logic                                         clk,
  input  logic [CWBITS-1:0]                            msg,
  input  logic [CACHESIZE*TAGSIZE-1:0]                 cache,
  input  logic [CTRSIZE-1:0]                           ctr,
  output logic [2*CWBITS*(1+TAGSIZE+CTRSIZE)-1:0]      msgOut
);

  localparam int PW = pkt_w(TAGSIZE, CTRSIZE);

  logic [2*CWBITS*PW-1:0] out_d;

  if (CACHESIZE > CWBITS) begin : g_spare
    logic unused_spare;
    assign unused_spare = ^cache[CACHESIZE*TAGSIZE-1:CWBITS*TAGSIZE];
  end

  // Wheat carries the true bit and its tag; chaff the inverse bit and a mirrored tag
  always_comb begin
    out_d = '0;
    for (int j = 0; j < CWBITS; j++) begin
      out_d[(2*j)*PW +: PW] =
        {msg[j], cache[j*TAGSIZE +: TAGSIZE], ctr};
      out_d[(2*j+1)*PW +: PW] =
        {~msg[j], cache[(CWBITS-1-j)*TAGSIZE +: TAGSIZE], ctr};
    end
  end

  // Capture the packet set once the inputs are stable
  always_ff @(posedge clk) begin
    msgOut <= out_d;
  end

endmodule

// File: rtl/cw_ctrl.sv
// Sequencer around cw: takes a message, fetches its MAC tags,
// then streams the wheat/chaff packets with the message counter.
module cw_ctrl
  import cw_pkg::*;
#(
  parameter int CWBITS    = 32,
  parameter int CTRSIZE   = 16,
  parameter int TAGSIZE   = 16,
  parameter int CACHESIZE = 64
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            msg_valid,
  output logic                            msg_ready,
  input  logic [CWBITS-1:0]               msg_data,
  output logic                            tag_req,
  output logic [$clog2(CWBITS)-1:0]       tag_idx,
  output logic [CTRSIZE-1:0]              tag_ctr,
  input  logic                            tag_ack,
  input  logic [TAGSIZE-1:0]              tag_data,
  output logic                            pkt_valid,
  input  logic                            pkt_ready,
  output logic [TAGSIZE+CTRSIZE:0]        pkt_data,
  output logic                            pkt_last,
  output logic [CTRSIZE-1:0]              ctr
);

  localparam int PW = pkt_w(TAGSIZE, CTRSIZE);
  localparam int IW = $clog2(CWBITS);
  localparam int EW = $clog2(2*CWBITS);

  if (CACHESIZE < CWBITS) begin : g_bad_cache
    $error("cw_ctrl: CACHESIZE must be >= CWBITS");
  end

  cw_ctrl_state_t      state_q, state_d;
  logic [CWBITS-1:0]   msg_q, msg_d;
  logic [IW-1:0]       fill_q, fill_d;
  logic [EW-1:0]       emit_q, emit_d;
  logic [CTRSIZE-1:0]  ctr_q, ctr_d;
  logic [TAGSIZE-1:0]  cache_q [CWBITS];
  logic [TAGSIZE-1:0]  cache_d [CWBITS];

  logic [CACHESIZE*TAGSIZE-1:0] cache_flat;
  logic [2*CWBITS*PW-1:0]       msg_out;

  // Next-state: accept, fill tags one at a time, settle, then emit
  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    fill_d  = fill_q;
    emit_d  = emit_q;
    ctr_d   = ctr_q;
    cache_d = cache_q;
    unique case (state_q)
      IDLE: begin
        if (msg_valid) begin
          msg_d   = msg_data;
          fill_d  = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (tag_ack) begin
          cache_d[fill_q] = tag_data;
          fill_d = fill_q + IW'(1);
          if (fill_q == IW'(CWBITS-1)) state_d = SETTLE;
        end
      end
      SETTLE: begin
        emit_d  = '0;
        state_d = EMIT;
      end
      EMIT: begin
        if (pkt_ready) begin
          emit_d = emit_q + EW'(1);
          if (emit_q == EW'(2*CWBITS-1)) begin
            ctr_d   = ctr_q + CTRSIZE'(1);
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers reset; message and cache are plain data
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= IDLE;
      fill_q  <= '0;
      emit_q  <= '0;
      ctr_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      emit_q  <= emit_d;
      ctr_q   <= ctr_d;
    end
  end

  // Message and tag cache storage
  always_ff @(posedge clk) begin
    msg_q   <= msg_d;
    cache_q <= cache_d;
  end

  // Present the filled entries; spare cache slots read as zero
  always_comb begin
    cache_flat = '0;
    for (int j = 0; j < CWBITS; j++) begin
      cache_flat[j*TAGSIZE +: TAGSIZE] = cache_q[j];
    end
  end

  cw #(
    .CWBITS   (CWBITS),
    .CTRSIZE  (CTRSIZE),
    .TAGSIZE  (TAGSIZE),
    .CACHESIZE(CACHESIZE)
  ) u_cw (
    .clk   (clk),
    .msg   (msg_q),
    .cache (cache_flat),
    .ctr   (ctr_q),
    .msgOut(msg_out)
  );

  assign msg_ready = (state_q == IDLE);
  assign tag_req   = (state_q == FILL);
  assign tag_idx   = fill_q;
  assign tag_ctr   = ctr_q;
  assign pkt_valid = (state_q == EMIT);
  assign pkt_last  = pkt_valid && (emit_q == EW'(2*CWBITS-1));
  assign pkt_data  = pkt_valid ? msg_out[emit_q*PW +: PW] : '0;
  assign ctr       = ctr_q;

endmodule

// File: tb/tb_cw_ctrl.sv
// Bench for cw_ctrl: behavioural packet model plus directed scenarios.
// Checks handshakes, packet contents, stalls, counter wrap and reset.
module tb_cw_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        msg_valid;
  logic        msg_ready;
  logic [31:0] msg_data;
  logic        tag_req;
  logic [4:0]  tag_idx;
  logic [15:0] tag_ctr;
  logic        tag_ack;
  logic [15:0] tag_data;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [32:0] pkt_data;
  logic        pkt_last;
  logic [15:0] ctr;

  cw_ctrl #(
    .CWBITS(32), .CTRSIZE(16), .TAGSIZE(16), .CACHESIZE(64)
  ) dut (
    .clk(clk), .rstn(rstn),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
    .tag_req(tag_req), .tag_idx(tag_idx), .tag_ctr(tag_ctr),
    .tag_ack(tag_ack), .tag_data(tag_data),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data),
    .pkt_last(pkt_last), .ctr(ctr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Stimulus knobs
  int          ack_dly = 0;
  bit          rdy_rand = 0;
  logic [15:0] tag_base = 16'h100;
  int          dcnt = 0;

  // Model state
  bit          armed = 0;
  bit          have_msg = 0;
  logic [31:0] m_msg;
  int          nfill = 0;
  int          settle = 0;
  int          nemit = 0;
  logic [15:0] ctr_m = '0;
  logic [15:0] m_tag [32];
  int          acc_cnt = 0;
  int          cyc = 0;
  int          last_acc = -1;
  bit          held_mode = 0;
  logic [32:0] cap [64];
  logic        cap_last [64];
  logic [32:0] cap1 [64];
  bit          prev_stall = 0;
  logic [32:0] prev_data;

  function automatic logic [32:0] exp_pkt(input int k);
    int j;
    j = k / 2;
    if (k % 2 == 0) return {m_msg[j], m_tag[j], ctr_m};
    return {~m_msg[j], m_tag[31-j], ctr_m};
  endfunction

  // Tag engine and packet consumer
  always @(negedge clk) begin
    if (ack_dly == 0) begin
      tag_ack = 1'b1;
    end else if (tag_req === 1'b1) begin
      if (dcnt >= ack_dly) begin
        tag_ack = 1'b1;
        dcnt = 0;
      end else begin
        tag_ack = 1'b0;
        dcnt++;
      end
    end else begin
      tag_ack = 1'b0;
      dcnt = 0;
    end
    tag_data = tag_base + 16'(tag_idx) + tag_ctr;
    pkt_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Compare DUT against the model on every edge
  always @(posedge clk) begin
    bit er, eq, ev;
    cyc++;
    er = !have_msg;
    eq = have_msg && nfill < 32;
    ev = have_msg && nfill == 32 && settle == 0;
    if (armed) begin
      chk("msg_ready", 64'(msg_ready), 64'(er));
      chk("tag_req", 64'(tag_req), 64'(eq));
      chk("pkt_valid", 64'(pkt_valid), 64'(ev));
      chk("ctr", 64'(ctr), 64'(ctr_m));
      if (ev) begin
        chk("pkt_data", 64'(pkt_data), 64'(exp_pkt(nemit)));
        chk("pkt_last", 64'(pkt_last), 64'(nemit == 63));
      end
      if (prev_stall) chk("stall_hold", 64'(pkt_data), 64'(prev_data));
      prev_stall = pkt_valid && !pkt_ready;
      prev_data = pkt_data;
    end
    if (rstn) begin
      armed = 1;
      have_msg = 0;
      nfill = 0;
      settle = 0;
      nemit = 0;
      ctr_m = '0;
      prev_stall = 0;
    end else if (armed) begin
      if (er && msg_valid) begin
        have_msg = 1;
        m_msg = msg_data;
        nfill = 0;
        settle = 1;
        nemit = 0;
        acc_cnt++;
        if (held_mode && last_acc >= 0)
          chk("accept_gap", 64'(cyc - last_acc), 64'd98);
        last_acc = cyc;
      end else if (eq && tag_ack) begin
        chk("tag_idx", 64'(tag_idx), 64'(nfill));
        chk("tag_ctr", 64'(tag_ctr), 64'(ctr_m));
        m_tag[nfill] = tag_data;
        nfill++;
      end else if (have_msg && nfill == 32 && settle > 0) begin
        settle--;
      end else if (ev && pkt_ready) begin
        cap[nemit] = pkt_data;
        cap_last[nemit] = pkt_last;
        if (nemit == 63) begin
          have_msg = 0;
          ctr_m++;
        end
        nemit++;
      end
    end
  end

  task automatic send(input logic [31:0] m);
    int a0;
    int n;
    a0 = acc_cnt;
    n = 0;
    msg_data = m;
    msg_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (acc_cnt == a0 && n < 50);
    msg_valid = 1'b0;
    chk("accepted", 64'(acc_cnt - a0), 64'd1);
  endtask

  task automatic wait_done(input int lim);
    int n;
    n = 0;
    while (have_msg && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("msg_done", 64'(have_msg), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int a0;
    rstn = 1'b1;
    msg_valid = 1'b0;
    msg_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_msg_ready", 64'(msg_ready), 64'd1);
    chk("rst_tag_req", 64'(tag_req), 64'd0);
    chk("rst_tag_idx", 64'(tag_idx), 64'd0);
    chk("rst_tag_ctr", 64'(tag_ctr), 64'd0);
    chk("rst_pkt_valid", 64'(pkt_valid), 64'd0);
    chk("rst_pkt_last", 64'(pkt_last), 64'd0);
    chk("rst_pkt_data", 64'(pkt_data), 64'd0);
    chk("rst_ctr", 64'(ctr), 64'd0);
    rstn = 1'b0;

    // Basic message, ack every cycle, no backpressure
    send(32'h0000_0001);
    wait_done(300);
    chk("pkt0", 64'(cap[0]), 64'({1'b1, 16'h100, 16'h0}));
    chk("pkt1", 64'(cap[1]), 64'({1'b0, 16'h11F, 16'h0}));
    chk("pkt62", 64'(cap[62]), 64'({1'b0, 16'h11F, 16'h0}));
    chk("pkt63", 64'(cap[63]), 64'({1'b1, 16'h100, 16'h0}));
    chk("pkt63_last", 64'(cap_last[63]), 64'd1);
    chk("ctr_after1", 64'(ctr), 64'd1);
    cap1 = cap;

    // Same tags under random backpressure
    rdy_rand = 1;
    tag_base = 16'h0FF;
    send(32'h0000_0001);
    wait_done(1000);
    rdy_rand = 0;
    for (int k = 0; k < 64; k++) begin
      chk("bp_seq", 64'(cap[k][32:16]), 64'(cap1[k][32:16]));
    end
    chk("bp_ctr_field", 64'(cap[5][15:0]), 64'd1);

    // Slow tag engine
    ack_dly = 3;
    tag_base = 16'h2000;
    send(32'hA5C3_0F96);
    wait_done(1000);
    ack_dly = 0;
    chk("ctr_after3", 64'(ctr), 64'd3);

    // Reset mid-emit at packet 10
    send(32'h1234_5678);
    n = 0;
    while (!(have_msg && nfill == 32 && settle == 0 && nemit == 10)
           && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("reached_idx10", 64'(nemit), 64'd10);
    rstn = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    chk("rst_emit_valid", 64'(pkt_valid), 64'd0);
    chk("rst_emit_ctr", 64'(ctr), 64'd0);
    chk("rst_emit_ready", 64'(msg_ready), 64'd1);
    tag_base = 16'h0300;
    send(32'h8000_0000);
    wait_done(300);
    chk("after_rst_pkt0", 64'(cap[0]), 64'({1'b0, 16'h300, 16'h0}));

    // Counter wrap
    @(negedge clk);
    force dut.ctr_q = 16'hFFFF;
    ctr_m = 16'hFFFF;
    @(negedge clk);
    release dut.ctr_q;
    send(32'hFFFF_0000);
    wait_done(300);
    chk("wrap_pkt_ctr", 64'(cap[0][15:0]), 64'hFFFF);
    chk("wrap_ctr", 64'(ctr), 64'd0);

    // msg_valid held: one accept per full message period
    held_mode = 1;
    last_acc = -1;
    a0 = acc_cnt;
    msg_data = 32'hC0DE_F00D;
    msg_valid = 1'b1;
    n = 0;
    while (acc_cnt < a0 + 3 && n < 400) begin
      @(negedge clk);
      n++;
    end
    msg_valid = 1'b0;
    chk("held_accepts", 64'(acc_cnt - a0), 64'd3);
    wait_done(300);
    held_mode = 0;

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
